lcd_text_refresher: RTL and testbench
=====================================

Name: lcd_text_refresher

Overview:
- Upstream stage of the HD44780 parallel LCD driver.
- Holds a 2x16 character screen buffer that the system writes at random; tracks which rows are dirty.
- Autonomously streams dirty rows to the driver's host transaction interface as one set-DDRAM-address command followed by 16 data bytes.
- Lets the rest of the design treat the display as simple memory-mapped text.

Parameters:
- COLS, 16, characters per row; fixed to 16 in this revision, sizes the column counter.
- ROW0_BASE, 8'h00, DDRAM address of row 0 column 0.
- ROW1_BASE, 8'h40, DDRAM address of row 1 column 0.
- BLANK_CHAR, 8'h20, fill value used at reset and on clear.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write one character into the buffer this cycle
- wr_row  in  1  target row (0/1)
- wr_col  in  4  target column 0..15
- wr_char  in  8  character code
- clr_screen  in  1  single-cycle pulse: fill buffer with BLANK_CHAR, mark both rows dirty
- lcd_init_done  in  1  driver init_done
- lcd_ready  in  1  driver host_ready
- lcd_valid  out  1  to driver host_valid
- lcd_rs  out  1  to driver host_rs (0=cmd, 1=data)
- lcd_data  out  8  to driver host_data
- busy  out  1  high whenever FSM is not in S_IDLE
- row_dirty  out  2  per-row dirty flags, bit r = row r

Behaviour:
- Reset (async, immediate, also mid-stream):
  - lcd_valid=0, lcd_rs=0, lcd_data=8'h00, busy=0, row_dirty=2'b00.
  - All 32 buffer cells = BLANK_CHAR; FSM=S_IDLE; column counter=0; round-robin pointer=0.
  - The driver's own init text remains until the first write.
- Buffer write: on clk edge with wr_en, cell[wr_row][wr_col] <= wr_char and row_dirty[wr_row] <= 1.
- clr_screen: all cells <= BLANK_CHAR and row_dirty <= 2'b11. If wr_en is high in the same cycle, the addressed cell takes wr_char (write wins over clear).
- Handshake: a transfer occurs on a clk edge where lcd_valid && lcd_ready.
  - lcd_rs and lcd_data are registered and held stable while lcd_valid is high and no transfer has occurred.
  - lcd_valid never drops without a transfer, except on reset.
  - The next item may be presented in the cycle after a transfer; valid may stay high.
- States:
  - S_IDLE:
    - Requires lcd_init_done=1 and row_dirty != 0.
    - Selects row r: if both rows are dirty, the row != last-served row (round-robin); otherwise the dirty row.
    - Clears row_dirty[r]; a same-cycle set by wr_en or clr_screen for row r wins and leaves it 1.
    - Loads lcd_rs=0, lcd_data=8'h80|ROWr_BASE, lcd_valid=1; goes to S_CMD.
  - S_CMD:
    - On transfer: col=0; loads lcd_rs=1, lcd_data=cell[r][0], lcd_valid=1; goes to S_CHAR.
  - S_CHAR:
    - On transfer with col<15: col+1; loads cell[r][col+1] (sampled at that edge, so the latest write is used).
    - On transfer with col==15: lcd_valid=0; last-served <= r; goes to S_IDLE.
- Per-row cost: exactly 17 transfers, in order 1 command then 16 data.
- Latency:
  - wr_en sampled at edge N in idle with init done gives lcd_valid=1 after edge N+1.
  - Back-to-back rows have one idle cycle (lcd_valid=0) between the last char and the next command.
- Writes during streaming:
  - A write to the row being streamed re-sets its dirty flag, so the row is re-sent completely after the current pass.
  - Already-sent columns are never patched mid-pass.
- lcd_init_done=0 blocks only leaving S_IDLE. Writes still update the buffer and dirty flags.
- The column counter wraps only by returning to S_IDLE, never 15->0 within a pass.
- busy = (state != S_IDLE).

Test Plan:
- Reset, lcd_init_done=0, write 'A'(8'h41) at row0 col3 -> row_dirty=2'b01, lcd_valid stays 0. Raise init_done with lcd_ready=1 -> stream 8'h80(rs0), then 20,20,20,41 and 12 more x 20 (rs1); row_dirty=0; busy falls after the 17th transfer.
- Write row1 col15 = 8'h5A, lcd_ready=1 -> first transfer 8'hC0 rs0; 16th data byte = 8'h5A; total 17 transfers.
- lcd_ready toggled randomly (about 30% high) during a row pass -> lcd_rs/lcd_data unchanged while valid && !ready; exactly 17 transfers in order.
- Both rows dirty via clr_screen, row1 served last before -> row0 streamed first (8'h80), then one idle cycle, then row1 (8'hC0); all 32 data bytes = 8'h20.
- During row0 streaming at col 5, write row0 col2 = 8'h31 -> current pass sends the old col2 value; row_dirty[0] re-set; second full pass carries 8'h31 at col2.
- Assert rst at col 8 of a pass -> same cycle lcd_valid=0, busy=0, row_dirty=0; after release no transfer until a new write.

Source files
------------

// File: rtl/lcd_text_refresher_if.sv
// Bundles the lcd_text_refresher ports other than clk and rst: the character
// write port, the screen-clear pulse, the driver host transaction bus and status.
// master: the refresher. slave: the system writing text plus the HD44780 driver.
interface lcd_text_refresher_if;
    // Character write port from the system.
    logic       wr_en;
    logic       wr_row;
    logic [3:0] wr_col;
    logic [7:0] wr_char;
    logic       clr_screen;

    // Driver host transaction bus (valid/ready).
    logic       lcd_init_done;
    logic       lcd_ready;
    logic       lcd_valid;
    logic       lcd_rs;
    logic [7:0] lcd_data;

    // Status.
    logic       busy;
    logic [1:0] row_dirty;

    modport master (
        input  wr_en, wr_row, wr_col, wr_char, clr_screen,
        input  lcd_init_done, lcd_ready,
        output lcd_valid, lcd_rs, lcd_data,
        output busy, row_dirty
    );

    modport slave (
        output wr_en, wr_row, wr_col, wr_char, clr_screen,
        output lcd_init_done, lcd_ready,
        input  lcd_valid, lcd_rs, lcd_data,
        input  busy, row_dirty
    );
endinterface

// File: rtl/lcd_text_refresher.sv
// Purpose: 2x16 text screen buffer that streams dirty rows to an HD44780 driver.
// Latency: a write sampled at edge N (idle, init done) raises lcd_valid after edge N+1.
// Backpressure: lcd_rs/lcd_data held while lcd_valid && !lcd_ready; valid never drops untransferred.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   bus (master)  wr_en/wr_row/wr_col/wr_char  random character writes
//                 clr_screen                   blank the buffer, mark both rows dirty
//                 lcd_init_done/lcd_ready      driver status and host-ready
//                 lcd_valid/lcd_rs/lcd_data    registered host transaction (rs 0=cmd, 1=data)
//                 busy, row_dirty              status: streaming in progress, per-row dirty flags
//
// Each dirty row is sent as one set-DDRAM-address command followed by its
// 16 character bytes. Rows are served round-robin when both are dirty.
module lcd_text_refresher #(
    parameter int         COLS       = 16,
    parameter logic [7:0] ROW0_BASE  = 8'h00,
    parameter logic [7:0] ROW1_BASE  = 8'h40,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst,
    lcd_text_refresher_if.master  bus
);

    localparam int            CW       = $clog2(COLS);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [7:0]    SET_DDRAM = 8'h80;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_CHAR = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q, state_nxt;
    logic [CW-1:0] col_q, col_nxt;
    logic          cur_row_q, cur_row_nxt;    // row being streamed
    logic          last_row_q, last_row_nxt;  // last row fully served
    logic          valid_q, valid_nxt;
    logic          rs_q, rs_nxt;
    logic [7:0]    data_q, data_nxt;
    logic [1:0]    dirty_q, dirty_nxt;
    logic [1:0]    dirty_clr;                 // row picked up by the FSM this cycle

    logic [7:0]    cells [2][COLS];

    logic          xfer;
    logic          sel_row;
    logic [CW-1:0] col_inc;

    // ------------------------------------------------------------------
    // Screen buffer. The write is placed after the clear so a same-cycle
    // write lands on top of the blank fill.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    cells[r][c] <= BLANK_CHAR;
                end
            end
        end else begin
            if (bus.clr_screen) begin
                for (int r = 0; r < 2; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        cells[r][c] <= BLANK_CHAR;
                    end
                end
            end
            if (bus.wr_en) begin
                cells[bus.wr_row][bus.wr_col] <= bus.wr_char;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dirty flags. The FSM clear is applied first so that a write or clear
    // arriving in the same cycle as the pickup re-marks the row; a row
    // written while it streams is therefore re-sent in full afterwards.
    // ------------------------------------------------------------------
    always_comb begin
        dirty_nxt = dirty_q & ~dirty_clr;
        if (bus.clr_screen) begin
            dirty_nxt = 2'b11;
        end
        if (bus.wr_en) begin
            if (bus.wr_row) begin
                dirty_nxt[1] = 1'b1;
            end else begin
                dirty_nxt[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirty_q <= 2'b00;
        end else begin
            dirty_q <= dirty_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Streaming FSM: state register plus registered host outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            cur_row_q  <= 1'b0;
            last_row_q <= 1'b0;
            valid_q    <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_nxt;
            col_q      <= col_nxt;
            cur_row_q  <= cur_row_nxt;
            last_row_q <= last_row_nxt;
            valid_q    <= valid_nxt;
            rs_q       <= rs_nxt;
            data_q     <= data_nxt;
        end
    end

    assign xfer    = valid_q & bus.lcd_ready;
    assign col_inc = col_q + 1'b1;

    // With both rows dirty, alternate away from the row served last;
    // otherwise take whichever row is dirty.
    assign sel_row = (&dirty_q) ? ~last_row_q : dirty_q[1];

    always_comb begin
        state_nxt    = state_q;
        col_nxt      = col_q;
        cur_row_nxt  = cur_row_q;
        last_row_nxt = last_row_q;
        valid_nxt    = valid_q;
        rs_nxt       = rs_q;
        data_nxt     = data_q;
        dirty_clr    = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (bus.lcd_init_done && (dirty_q != 2'b00)) begin
                    cur_row_nxt = sel_row;
                    dirty_clr   = sel_row ? 2'b10 : 2'b01;
                    rs_nxt      = 1'b0;
                    data_nxt    = SET_DDRAM | (sel_row ? ROW1_BASE : ROW0_BASE);
                    valid_nxt   = 1'b1;
                    state_nxt   = S_CMD;
                end
            end

            S_CMD: begin
                if (xfer) begin
                    col_nxt   = '0;
                    rs_nxt    = 1'b1;
                    data_nxt  = cells[cur_row_q][0];
                    valid_nxt = 1'b1;
                    state_nxt = S_CHAR;
                end
            end

            S_CHAR: begin
                if (xfer) begin
                    if (col_q == LAST_COL) begin
                        // Counter restarts only through idle, never mid-pass.
                        col_nxt      = '0;
                        valid_nxt    = 1'b0;
                        last_row_nxt = cur_row_q;
                        state_nxt    = S_IDLE;
                    end else begin
                        // Buffer is read at the transfer edge, so the byte
                        // reflects every write completed before it.
                        col_nxt   = col_inc;
                        data_nxt  = cells[cur_row_q][col_inc];
                        valid_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.lcd_valid = valid_q;
    assign bus.lcd_rs    = rs_q;
    assign bus.lcd_data  = data_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.row_dirty = dirty_q;

endmodule

// File: tb/tb_lcd_text_refresher.sv
// Directed bench for lcd_text_refresher: a per-cycle vector table for the
// first row pass, then hand-written sequences for row selection, backpressure,
// mid-pass writes and asynchronous reset.
module tb_lcd_text_refresher;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lcd_text_refresher_if ifc ();

    lcd_text_refresher dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         cyc;
    } xfer_t;

    xfer_t xq [$];
    int    cyc = 0;

    // Transfer log: one entry per edge with valid && ready.
    always @(posedge clk) begin
        cyc++;
        if (!rst && ifc.lcd_valid && ifc.lcd_ready) begin
            xq.push_back('{rs: ifc.lcd_rs, data: ifc.lcd_data, cyc: cyc});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold-while-stalled check, enabled for the backpressure sequence.
    logic       chk_stable = 1'b0;
    logic       p_valid = 1'b0, p_ready = 1'b0, p_rs = 1'b0;
    logic [7:0] p_data = 8'h00;
    always @(posedge clk) begin
        if (chk_stable && !rst && p_valid && !p_ready) begin
            chk("stall_valid", 32'(ifc.lcd_valid), 32'd1);
            chk("stall_rs", 32'(ifc.lcd_rs), 32'(p_rs));
            chk("stall_data", 32'(ifc.lcd_data), 32'(p_data));
        end
        p_valid = ifc.lcd_valid;
        p_ready = ifc.lcd_ready;
        p_rs    = ifc.lcd_rs;
        p_data  = ifc.lcd_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic row, input logic [3:0] col, input logic [7:0] ch);
        ifc.wr_en   = 1'b1;
        ifc.wr_row  = row;
        ifc.wr_col  = col;
        ifc.wr_char = ch;
        step();
        ifc.wr_en   = 1'b0;
    endtask

    // Wait until n transfers are logged and the refresher is back in idle.
    task automatic wait_xfers(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (xq.size() >= n && !ifc.busy && !ifc.lcd_valid) break;
            step();
        end
        chk({name, "_count"}, 32'(xq.size()), 32'(n));
    endtask

    // Compare a 17-transfer pass starting at xq[base]: command then 16 chars.
    task automatic check_pass(input string tag, input int base, input logic [7:0] cmd,
                              input logic [16*8-1:0] ex);
        if (xq.size() < base + 17) begin
            chk({tag, "_len"}, 32'(xq.size()), 32'(base + 17));
        end else begin
            chk({tag, "_cmd_rs"}, 32'(xq[base].rs), 32'd0);
            chk({tag, "_cmd"}, 32'(xq[base].data), 32'(cmd));
            for (int c = 0; c < 16; c++) begin
                chk($sformatf("%s_rs_c%0d", tag, c), 32'(xq[base + 1 + c].rs), 32'd1);
                chk($sformatf("%s_data_c%0d", tag, c), 32'(xq[base + 1 + c].data),
                    32'(ex[c*8 +: 8]));
            end
        end
    endtask

    function automatic logic [16*8-1:0] blank_row();
        logic [16*8-1:0] r;
        for (int c = 0; c < 16; c++) r[c*8 +: 8] = 8'h20;
        return r;
    endfunction

    typedef struct {
        logic       wr_en;
        logic       wr_row;
        logic [3:0] wr_col;
        logic [7:0] wr_char;
        logic       init;
        logic       ready;
        logic       e_valid;
        logic       e_rs;
        logic [7:0] e_data;
        logic       e_busy;
        logic [1:0] e_dirty;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [16*8-1:0] ex;

        // ---------------- vector table: first pass of row 0 ----------------
        tbl[0] = '{1'b1, 1'b0, 4'd3, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01};
        tbl[1] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01};
        tbl[2] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 2'b00};
        for (int k = 0; k < 16; k++) begin
            tbl[3 + k] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1,
                           1'b1, 1'b1, (k == 3) ? 8'h41 : 8'h20, 1'b1, 2'b00};
        end
        tbl[19] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 1'b0, 2'b00};

        ifc.wr_en = 1'b0; ifc.wr_row = 1'b0; ifc.wr_col = 4'd0; ifc.wr_char = 8'h00;
        ifc.clr_screen = 1'b0; ifc.lcd_init_done = 1'b0; ifc.lcd_ready = 1'b0;

        #12;
        chk("rst_valid", 32'(ifc.lcd_valid), 32'd0);
        chk("rst_rs", 32'(ifc.lcd_rs), 32'd0);
        chk("rst_data", 32'(ifc.lcd_data), 32'h00);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_dirty", 32'(ifc.row_dirty), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        for (int i = 0; i < 20; i++) begin
            ifc.wr_en = tbl[i].wr_en; ifc.wr_row = tbl[i].wr_row;
            ifc.wr_col = tbl[i].wr_col; ifc.wr_char = tbl[i].wr_char;
            ifc.lcd_init_done = tbl[i].init; ifc.lcd_ready = tbl[i].ready;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(ifc.lcd_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_busy", i), 32'(ifc.busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d_dirty", i), 32'(ifc.row_dirty), 32'(tbl[i].e_dirty));
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d_rs", i), 32'(ifc.lcd_rs), 32'(tbl[i].e_rs));
                chk($sformatf("vec%0d_data", i), 32'(ifc.lcd_data), 32'(tbl[i].e_data));
            end
        end
        ifc.wr_en = 1'b0;
        chk("tbl_xfers", 32'(xq.size()), 32'd17);

        // ---------------- row 1, last column ----------------
        xq.delete();
        write_char(1'b1, 4'd15, 8'h5A);
        wait_xfers("row1", 17, 200);
        ex = blank_row();
        ex[15*8 +: 8] = 8'h5A;
        check_pass("row1", 0, 8'hC0, ex);
        chk("row1_dirty", 32'(ifc.row_dirty), 32'd0);

        // ---------------- clear: both dirty, row 1 served last ----------------
        xq.delete();
        ifc.clr_screen = 1'b1;
        step();
        ifc.clr_screen = 1'b0;
        chk("clr_dirty", 32'(ifc.row_dirty), 32'b11);
        wait_xfers("clr", 34, 300);
        check_pass("clr_r0", 0, 8'h80, blank_row());
        check_pass("clr_r1", 17, 8'hC0, blank_row());
        if (xq.size() >= 34) begin
            chk("clr_gap", 32'(xq[17].cyc - xq[16].cyc), 32'd2);
        end

        // ---------------- backpressure: ready ~30% ----------------
        xq.delete();
        ifc.lcd_ready = 1'b0;
        chk_stable = 1'b1;
        write_char(1'b0, 4'd0, 8'h42);
        write_char(1'b0, 4'd3, 8'h41);
        for (int i = 0; i < 2000; i++) begin
            if (xq.size() >= 17 && !ifc.busy) break;
            ifc.lcd_ready = ($urandom_range(0, 99) < 30);
            step();
        end
        chk_stable = 1'b0;
        ifc.lcd_ready = 1'b1;
        chk("bp_count", 32'(xq.size()), 32'd17);
        ex = blank_row();
        ex[0*8 +: 8] = 8'h42;
        ex[3*8 +: 8] = 8'h41;
        check_pass("bp", 0, 8'h80, ex);

        // ---------------- write to the row being streamed ----------------
        xq.delete();
        write_char(1'b0, 4'd7, 8'h55);
        for (int i = 0; i < 100; i++) begin
            if (xq.size() >= 6) break;
            step();
        end
        chk("mid_reach_col5", 32'(xq.size()), 32'd6);
        write_char(1'b0, 4'd2, 8'h31);
        chk("mid_redirty", 32'(ifc.row_dirty), 32'b01);
        wait_xfers("mid", 34, 300);
        ex = blank_row();
        ex[0*8 +: 8] = 8'h42;
        ex[3*8 +: 8] = 8'h41;
        ex[7*8 +: 8] = 8'h55;
        check_pass("mid_p1", 0, 8'h80, ex);
        ex[2*8 +: 8] = 8'h31;
        check_pass("mid_p2", 17, 8'h80, ex);
        chk("mid_dirty_end", 32'(ifc.row_dirty), 32'd0);

        // ---------------- asynchronous reset mid-pass ----------------
        xq.delete();
        write_char(1'b1, 4'd1, 8'h66);
        for (int i = 0; i < 100; i++) begin
            if (xq.size() >= 9) break;
            step();
        end
        chk("rstmid_reach_col8", 32'(xq.size()), 32'd9);
        write_char(1'b0, 4'd9, 8'h77);
        chk("rstmid_dirty_before", 32'(ifc.row_dirty), 32'b01);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(ifc.lcd_valid), 32'd0);
        chk("rstmid_busy", 32'(ifc.busy), 32'd0);
        chk("rstmid_dirty", 32'(ifc.row_dirty), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        xq.delete();
        for (int i = 0; i < 30; i++) step();
        chk("rstmid_no_xfer", 32'(xq.size()), 32'd0);
        chk("rstmid_idle_valid", 32'(ifc.lcd_valid), 32'd0);
        // Buffer must be blank again: row 1 col 1 no longer holds 8'h66.
        write_char(1'b1, 4'd0, 8'h30);
        wait_xfers("post_rst", 17, 200);
        ex = blank_row();
        ex[0*8 +: 8] = 8'h30;
        check_pass("post_rst", 0, 8'hC0, ex);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
